bus_wrr_sched: RTL and testbench

BUS_WRR_SCHED -- requirements
Module: bus_wrr_sched

---
 rtl/bus_sched_pkg.sv | 21 ++
 rtl/bus_wrr_sched_rr_pick.sv | 28 ++
 rtl/bus_wrr_sched.sv | 119 +++++++++++
 tb/tb_bus_wrr_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the weighted round-robin bus scheduler.
// Destination field is the top byte of each packet.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_ROUTE
    } state_t;

    localparam logic [7:0] BROADCAST_ID = 8'hFF;

    // Widest packet the destination helper accepts; callers zero-extend.
    localparam int unsigned PKT_MAX_W = 64;

    function automatic logic [7:0] extract_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned         pkt_w);
        return pkt[pkt_w-1 -: 8];
    endfunction

endpackage

// File: rtl/bus_wrr_sched_rr_pick.sv
// Rotating-priority encoder: picks the first set request searching upward
// from last+1 with wrap-around.
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = W'((32'(last) + i) % N);
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_wrr_sched.sv
// Weighted round-robin scheduler moving packets from driver FIFOs to
// receiver FIFOs over one shared bus (unicast, broadcast, drop on bad dest).
module bus_wrr_sched
    import bus_sched_pkg::*;
#(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = BROADCAST_ID,
    parameter int         wgt_w     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
    input  logic [drvrs-1:0]                 full,
    input  logic [drvrs-1:0][wgt_w-1:0]      weight,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [pckg_sz-1:0]               D_push,
    output logic [$clog2(drvrs)-1:0]         grant_id,
    output logic                             busy,
    output logic [7:0]                       drop_cnt
);

    localparam int GW = $clog2(drvrs);

    state_t            state, state_n;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     pick;
    logic              pick_vld;
    logic [wgt_w-1:0]  quota;
    logic [7:0]        dest;
    logic [GW-1:0]     dest_idx;
    logic              dest_bcast;
    logic              dest_uni;
    logic              route_done;
    logic              drop;
    logic [drvrs-1:0]  src_mask;

    rr_pick #(.N(drvrs)) u_pick (
        .req   (pndng),
        .last  (last_grant),
        .grant (pick),
        .valid (pick_vld)
    );

    // Destination is taken from the captured packet, so it is stable while blocked.
    assign dest       = extract_dest(PKT_MAX_W'(D_push), pckg_sz);
    assign dest_idx   = dest[GW-1:0];
    assign dest_bcast = (dest == broadcast);
    assign dest_uni   = !dest_bcast && (32'(dest) < drvrs);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_n    = state;
        pop        = '0;
        push       = '0;
        route_done = 1'b0;
        drop       = 1'b0;
        src_mask   = '0;
        src_mask[grant_id] = 1'b1;

        case (state)
            ST_IDLE: begin
                if (pick_vld) state_n = ST_POP;
            end
            ST_POP: begin
                pop[grant_id] = 1'b1;
                state_n       = ST_ROUTE;
            end
            ST_ROUTE: begin
                if (dest_bcast) begin
                    if ((full & ~src_mask) == '0) begin
                        push       = ~src_mask;
                        route_done = 1'b1;
                    end
                end else if (dest_uni) begin
                    if (!full[dest_idx]) begin
                        push[dest_idx] = 1'b1;
                        route_done     = 1'b1;
                    end
                end else begin
                    drop       = 1'b1;
                    route_done = 1'b1;
                end
                if (route_done)
                    state_n = (quota != '0 && pndng[grant_id]) ? ST_POP : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(drvrs - 1);
            quota      <= '0;
            D_push     <= '0;
            drop_cnt   <= '0;
        end else begin
            state <= state_n;
            // Weight is sampled only when a new grant is issued; zero means one.
            if (state == ST_IDLE && pick_vld) begin
                grant_id <= pick;
                quota    <= (weight[pick] == '0) ? wgt_w'(1) : weight[pick];
            end
            if (state == ST_POP) begin
                D_push <= D_pop[grant_id];
                quota  <= quota - wgt_w'(1);
            end
            if (route_done && state_n == ST_IDLE)
                last_grant <= grant_id;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bus_wrr_sched.sv
// Scoreboard bench for bus_wrr_sched: directed packets, expected pops and
// pushes queued at load time and consumed by a negedge monitor.
module tb_bus_wrr_sched;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [3:0]            pndng;
    logic [3:0][15:0]      D_pop;
    logic [3:0]            full;
    logic [3:0][3:0]       weight;
    logic [3:0]            pop;
    logic [3:0]            push;
    logic [15:0]           D_push;
    logic [1:0]            grant_id;
    logic                  busy;
    logic [7:0]            drop_cnt;

    typedef struct packed {
        logic [3:0]  vec;
        logic [15:0] data;
    } push_t;

    push_t       exp_push[$];
    logic [3:0]  exp_pop[$];
    logic [15:0] q[4][$];
    logic [3:0]  e_pop;
    push_t       e_push;
    logic [3:0]  pop_s;
    int          checks = 0;
    int          errors = 0;

    bus_wrr_sched #(
        .drvrs    (4),
        .pckg_sz  (16),
        .broadcast(8'hFF),
        .wgt_w    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .full     (full),
        .weight   (weight),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            pndng[i] = (q[i].size() != 0);
            D_pop[i] = (q[i].size() != 0) ? q[i][0] : 16'h0000;
        end
    endtask

    // One clock; the tb FIFO heads advance where pop was high before the edge.
    task automatic tick();
        @(negedge clk);
        pop_s = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pop_s[i] && q[i].size() != 0) void'(q[i].pop_front());
        refresh();
    endtask

    task automatic load(input int d, input logic [15:0] pkt, input logic [3:0] pv);
        q[d].push_back(pkt);
        exp_pop.push_back(4'(1 << d));
        if (pv != 4'b0000) exp_push.push_back('{vec: pv, data: pkt});
        refresh();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((pndng != 4'b0000 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    always @(negedge clk) begin
        if ((pop | push) != 4'b0000) begin
            checks++;
            if ((pop != 4'b0000 && push != 4'b0000) || !$onehot0(pop)) begin
                errors++;
                $display("FAIL pop_push_excl: pop=%b push=%b", pop, push);
            end
        end
        if (pop != 4'b0000) begin
            checks++;
            if (exp_pop.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %b expected none", pop);
            end else begin
                e_pop = exp_pop.pop_front();
                if (pop !== e_pop) begin
                    errors++;
                    $display("FAIL pop_order: got %b expected %b", pop, e_pop);
                end
            end
        end
        if (push != 4'b0000) begin
            checks++;
            if (exp_push.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: got %b/%h expected none", push, D_push);
            end else begin
                e_push = exp_push.pop_front();
                if (push !== e_push.vec || D_push !== e_push.data) begin
                    errors++;
                    $display("FAIL push_data: got %b/%h expected %b/%h",
                             push, D_push, e_push.vec, e_push.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        pndng  = '0;
        D_pop  = '0;
        full   = '0;
        weight = 16'h1111;
        repeat (3) tick();
        chk("rst_pop",      32'(pop),      32'h0);
        chk("rst_push",     32'(push),     32'h0);
        chk("rst_dpush",    32'(D_push),   32'h0);
        chk("rst_grant",    32'(grant_id), 32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_drop",     32'(drop_cnt), 32'h0);
        reset = 1'b0;

        // Single unicast packet and its latency.
        load(2, 16'h01AB, 4'b0010);
        tick();
        chk("lat_pop",   32'(pop),    32'h4);
        chk("lat_busy",  32'(busy),   32'h1);
        tick();
        chk("lat_push",  32'(push),   32'h2);
        chk("lat_data",  32'(D_push), 32'h01AB);
        chk("lat_nopop", 32'(pop),    32'h0);
        tick();
        chk("lat_idle",  32'(busy),   32'h0);
        chk("lat_push0", 32'(push),   32'h0);

        // Round-robin order 0,1,2,3,0 from reset; driver 2 addresses itself.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(0, 16'h0211, 4'b0100);
        load(1, 16'h0322, 4'b1000);
        load(2, 16'h0233, 4'b0100);
        load(3, 16'h0144, 4'b0010);
        load(0, 16'h0155, 4'b0010);
        drain("rr_drain", 100);
        chk("rr_pops_left", 32'(exp_pop.size()), 32'd0);
        chk("rr_last_grant", 32'(grant_id), 32'd0);

        // Weighted burst: driver 0 weight 3 against driver 1 weight 1.
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        weight = 16'h1113;
        load(0, 16'h0201, 4'b0100);
        load(0, 16'h0202, 4'b0100);
        load(0, 16'h0203, 4'b0100);
        load(1, 16'h0311, 4'b1000);
        load(0, 16'h0204, 4'b0100);
        load(1, 16'h0312, 4'b1000);
        drain("wrr_drain", 100);
        chk("wrr_pushes_left", 32'(exp_push.size()), 32'd0);

        // Broadcast from driver 3 held off by full[1] for five cycles.
        weight = 16'h1111;
        full   = 4'b0010;
        load(3, 16'hFF55, 4'b0111);
        tick();
        chk("bc_pop", 32'(pop), 32'h8);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bc_blocked_push", 32'(push),   32'h0);
            chk("bc_hold_data",    32'(D_push), 32'hFF55);
            tick();
        end
        full = 4'b0000;
        #1;
        chk("bc_push", 32'(push), 32'h7);
        tick();
        chk("bc_done_busy", 32'(busy), 32'h0);
        chk("bc_done_push", 32'(push), 32'h0);

        // Invalid destination drops and saturating counter.
        weight = 16'h111F;
        load(0, 16'h0900, 4'b0000);
        repeat (3) tick();
        chk("drop_one",  32'(drop_cnt), 32'd1);
        chk("drop_idle", 32'(busy),     32'd0);
        for (int i = 0; i < 299; i++) load(0, 16'h0900, 4'b0000);
        drain("drop_drain", 2000);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Reset while blocked in ROUTE discards the packet.
        weight = 16'h1111;
        full   = 4'b0010;
        load(2, 16'h0177, 4'b0000);
        tick();
        tick();
        chk("rr_blk_busy", 32'(busy), 32'h1);
        chk("rr_blk_push", 32'(push), 32'h0);
        reset = 1'b1;
        tick();
        chk("rstr_push",  32'(push),     32'h0);
        chk("rstr_busy",  32'(busy),     32'h0);
        chk("rstr_drop",  32'(drop_cnt), 32'h0);
        chk("rstr_data",  32'(D_push),   32'h0);
        reset = 1'b0;
        full  = 4'b0000;
        tick();
        chk("rstr_push_after", 32'(push), 32'h0);
        chk("rstr_idle_after", 32'(busy), 32'h0);

        chk("final_pops_left",   32'(exp_pop.size()),  32'd0);
        chk("final_pushes_left", 32'(exp_push.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
